// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage of the 5-stage MIPS pipeline.
// Holds SR, Cause, EPC and PRId, and raises Req when an interrupt or exception is taken.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE  = 32'h2021_0701,
    parameter logic [31:0] EXC_HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_M,
    input  logic        bd_M,
    input  logic [4:0]  exc_code_M,
    input  logic [5:0]  HWInt,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        exl_clr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] EPC_out,
    output logic [31:0] handler_pc,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [5:0]  ip_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg;

    logic [5:0]  pending;
    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_code_next;
    logic [31:0] victim_pc;
    logic [31:0] epc_next;
    logic [31:0] sr_value;
    logic [31:0] cause_value;

    // Per-line masking of the level-sensitive interrupt inputs.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_pending
            assign pending[gi] = HWInt[gi] & im_reg[gi];
        end
    endgenerate

    assign int_req       = (|pending) & ie_reg & ~exl_reg;
    assign exc_req       = (exc_code_M != 5'd0) & ~exl_reg;
    assign Req           = int_req | exc_req;
    assign exc_code_next = int_req ? 5'd0 : exc_code_M;

    // A delay-slot victim resumes at its branch, one word earlier.
    assign victim_pc = bd_M ? (pc_M - 32'd4) : pc_M;
    assign epc_next  = {victim_pc[31:2], 2'b00};

    assign sr_value    = {16'b0, im_reg, 8'b0, exl_reg, ie_reg};
    assign cause_value = {bd_reg, 15'b0, ip_reg, 3'b0, exc_code_reg, 2'b0};

    assign EPC_out    = epc_reg;
    assign handler_pc = EXC_HANDLER;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_reg       <= 6'd0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_reg       <= 6'd0;
            exc_code_reg <= 5'd0;
            epc_reg      <= 32'd0;
        end else begin
            ip_reg <= HWInt;
            // Taking a trap outranks eret, which outranks mtc0.
            if (Req) begin
                exl_reg      <= 1'b1;
                bd_reg       <= bd_M;
                exc_code_reg <= exc_code_next;
                epc_reg      <= epc_next;
            end else if (exl_clr) begin
                exl_reg <= 1'b0;
            end else if (cp0_we) begin
                if (cp0_addr == ADDR_SR) begin
                    im_reg  <= cp0_wdata[15:10];
                    exl_reg <= cp0_wdata[1];
                    ie_reg  <= cp0_wdata[0];
                end else if (cp0_addr == ADDR_EPC) begin
                    epc_reg <= {cp0_wdata[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = sr_value;
            ADDR_CAUSE: cp0_rdata = cause_value;
            ADDR_EPC:   cp0_rdata = epc_reg;
            ADDR_PRID:  cp0_rdata = PRID_VALUE;
            default:    cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus random traffic against a word-level CP0 model.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h2021_0701;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_M;
    logic        bd_M;
    logic [4:0]  exc_code_M;
    logic [5:0]  HWInt;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        exl_clr;
    logic [31:0] cp0_rdata;
    logic [31:0] EPC_out;
    logic [31:0] handler_pc;
    logic        Req;

    int total = 0;
    int bad = 0;

    // Reference state kept as whole architectural words.
    logic [31:0] m_sr, m_cause, m_epc;
    logic        last_req;

    cp0_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_M       (pc_M),
        .bd_M       (bd_M),
        .exc_code_M (exc_code_M),
        .HWInt      (HWInt),
        .cp0_we     (cp0_we),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .exl_clr    (exl_clr),
        .cp0_rdata  (cp0_rdata),
        .EPC_out    (EPC_out),
        .handler_pc (handler_pc),
        .Req        (Req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_req();
        logic ie, exl;
        logic [5:0] im;
        ie  = m_sr[0];
        exl = m_sr[1];
        im  = m_sr[15:10];
        return (((HWInt & im) != 6'd0) && ie && !exl) || ((exc_code_M != 5'd0) && !exl);
    endfunction

    function automatic logic [31:0] model_rdata(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    // One instruction in M: drive, check combinational outputs, clock, advance model.
    task automatic apply(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                         input logic [5:0] hw, input logic we, input logic [4:0] addr,
                         input logic [31:0] wdata, input logic eret);
        logic r;
        logic [31:0] vpc;
        pc_M = pc; bd_M = bd; exc_code_M = code; HWInt = hw;
        cp0_we = we; cp0_addr = addr; cp0_wdata = wdata; exl_clr = eret;
        #1;
        r = model_req();
        last_req = Req;
        check("req", {31'd0, Req}, {31'd0, r});
        check("rdata", cp0_rdata, model_rdata(addr));
        check("epc_out", EPC_out, m_epc);
        @(posedge clk);
        if (r) begin
            vpc = bd ? pc - 32'd4 : pc;
            m_epc = vpc & 32'hFFFF_FFFC;
            m_sr = m_sr | 32'd2;
            m_cause = ({31'd0, bd} << 31) | ({26'd0, hw} << 10)
                      | ({27'd0, ((m_sr[15:10] & hw) != 0 && m_sr[0] && (m_sr | 32'd0) != 0 && r && ((HWInt & m_sr[15:10]) != 0) && m_sr[0]) ? 5'd0 : code} << 2);
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
            if (eret)
                m_sr = m_sr & ~32'd2;
            else if (we && addr == 5'd12)
                m_sr = wdata & 32'h0000_FC03;
            else if (we && addr == 5'd14)
                m_epc = wdata & 32'hFFFF_FFFC;
        end
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        cp0_we = 1'b0;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    initial begin
        reset = 1'b1;
        pc_M = 0; bd_M = 0; exc_code_M = 0; HWInt = 0;
        cp0_we = 0; cp0_addr = 0; cp0_wdata = 0; exl_clr = 0;
        m_sr = 0; m_cause = 0; m_epc = 0; last_req = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'd0, Req}, 32'd0);
        check("rst_handler", handler_pc, HANDLER);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a cycle wipes SR even with every line set.
        apply(32'h3000, 0, 0, 6'h00, 1, 5'd12, 32'h0000_FC03, 0);
        look("t1_sr_set", 5'd12, 32'h0000_FC03);
        #2 reset = 1'b1;
        m_sr = 0; m_cause = 0; m_epc = 0;
        #2 reset = 1'b0;
        @(negedge clk);
        HWInt = 6'h3F;
        look("t1_sr", 5'd12, 32'd0);
        look("t1_cause", 5'd13, 32'd0);
        look("t1_epc", 5'd14, 32'd0);
        apply(32'h3004, 0, 0, 6'h3F, 0, 5'd12, 0, 0);
        check("t1_req", {31'd0, last_req}, 32'd0);

        // Enabled interrupt.
        apply(32'h3008, 0, 0, 6'h00, 1, 5'd12, 32'h0000_0401, 0);
        apply(32'h3010, 0, 0, 6'h01, 0, 5'd14, 0, 0);
        check("t2_req", {31'd0, last_req}, 32'd1);
        look("t2_epc", 5'd14, 32'h0000_3010);
        look("t2_cause", 5'd13, 32'h0000_0400);
        look("t2_sr", 5'd12, 32'h0000_0403);

        // Exception in a delay slot with interrupts disabled.
        apply(32'h3014, 0, 0, 6'h00, 1, 5'd12, 32'h0, 0);
        apply(32'h3020, 1, 5'd4, 6'h00, 0, 5'd13, 0, 0);
        check("t3_req", {31'd0, last_req}, 32'd1);
        look("t3_epc", 5'd14, 32'h0000_301C);
        look("t3_cause", 5'd13, 32'h8000_0010);

        // Interrupt beats exception; then EXL blocks everything.
        apply(32'h3030, 0, 0, 6'h00, 1, 5'd12, 32'h0000_0401, 0);
        apply(32'h3040, 0, 5'd12, 6'h01, 0, 5'd13, 0, 0);
        check("t4_req", {31'd0, last_req}, 32'd1);
        look("t4_cause", 5'd13, 32'h0000_0400);
        apply(32'h3050, 0, 5'd12, 6'h01, 0, 5'd14, 0, 0);
        check("t4_exl_req", {31'd0, last_req}, 32'd0);
        look("t4_epc", 5'd14, 32'h0000_3040);
        look("t4_cause2", 5'd13, 32'h0000_0400);

        // eret with the line still high re-raises Req; a colliding mtc0 EPC is dropped.
        apply(32'h3054, 0, 0, 6'h01, 0, 5'd12, 0, 1);
        look("t5_sr", 5'd12, 32'h0000_0401);
        check("t5_rereq", {31'd0, Req}, 32'd1);
        apply(32'h3060, 0, 0, 6'h01, 1, 5'd14, 32'hDEAD_BEE0, 0);
        look("t5_epc", 5'd14, 32'h0000_3060);

        // PRId and read-only Cause.
        look("t6_prid", 5'd15, PRID);
        look("t6_cause_old", 5'd13, 32'h0000_0400);
        apply(32'h3064, 0, 0, 6'h00, 1, 5'd13, 32'hFFFF_FFFF, 0);
        look("t6_cause", 5'd13, 32'h0000_0000);

        // Random traffic: mtc0 and eret never share an instruction slot.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] code, addr;
            logic [5:0] hw;
            logic we, eret;
            int sel;
            code = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            sel  = $urandom_range(0, 7);
            eret = (sel == 0);
            we   = (sel >= 5);
            case ($urandom_range(0, 4))
                0: addr = 5'd12;
                1: addr = 5'd13;
                2: addr = 5'd14;
                3: addr = 5'd15;
                default: addr = 5'($urandom);
            endcase
            apply($urandom, 1'($urandom), code, hw, we, addr, $urandom, eret);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
